// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and parameter limits for fifo_n.
// FIFO_N_BYPASS_EN (default undefined) makes an empty FIFO pass indata straight through.
package fifo_pkg;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 1024;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cw_of(input int d);
    return clog2(d + 1);
  endfunction
  function automatic int pw_of(input int d);
    return (d > 1) ? clog2(d) : 1;
  endfunction
  localparam int CW_DEF = cw_of(4);
  localparam int PW_DEF = pw_of(4);
endpackage

// File: rtl/fifo_n_if.sv
// fifo_n_if: addq/shiftq queue handshake plus status flags between producer and consumer.
interface fifo_n_if
  import fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 4
);
  localparam int CW = cw_of(depth);
  logic addq;
  logic shiftq;
  logic [width-1:0] indata;
  logic [width-1:0] outdata;
  logic full;
  logic empty;
  logic almost_full;
  logic [CW-1:0] count;
  logic overflow;
  logic underflow;
  modport master (
    output addq, shiftq, indata,
    input  full, empty, almost_full, count, outdata, overflow, underflow
  );
  modport slave (
    input  addq, shiftq, indata,
    output full, empty, almost_full, count, outdata, overflow, underflow
  );
endinterface

// File: rtl/fifo_n_ptr.sv
// fifo_n_ptr: modulo-depth pointer with increment enable; wraps by compare-and-clear.
module fifo_n_ptr #(
  parameter int depth = 4,
  parameter int pw = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic [pw-1:0] ptr
);
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (inc) ptr <= (ptr == pw'(depth - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_n.sv
// fifo_n: depth x width synchronous FIFO with occupancy, almost-full and sticky error flags.
// Define FIFO_N_BYPASS_EN to let an empty FIFO pass indata straight through like a zero-depth queue.
module fifo_n
  import fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 4,
  parameter int afull_thresh = depth - 1
) (
  input  logic clk,
  input  logic reset,
  fifo_n_if.slave q
);
  localparam int CW = cw_of(depth);
  localparam int PW = pw_of(depth);
  if (depth < DEPTH_MIN || depth > DEPTH_MAX) begin : g_bad_depth
    $error("fifo_n: depth out of range");
  end
  logic [width-1:0] mem [depth];
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr, rd;
  logic is_empty, byp, pop_ok, push_ok, ov, un;
  assign is_empty = cnt == '0;
`ifdef FIFO_N_BYPASS_EN
  assign byp = q.addq && q.shiftq && is_empty;
  assign q.empty = is_empty && !q.addq;
  assign q.outdata = is_empty ? q.indata : mem[rd];
`else
  assign byp = 1'b0;
  assign q.empty = is_empty;
  assign q.outdata = mem[rd];
`endif
  assign pop_ok = q.shiftq && !is_empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = q.addq && !byp && (cnt != CW'(depth) || pop_ok);
  assign q.full = cnt == CW'(depth);
  assign q.almost_full = cnt >= CW'(afull_thresh);
  assign q.count = cnt;
  assign q.overflow = ov;
  assign q.underflow = un;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      ov <= 1'b0;
      un <= 1'b0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
      if (q.addq && !push_ok && !byp) ov <= 1'b1;
      if (q.shiftq && is_empty && !byp) un <= 1'b1;
      if (push_ok) mem[wr] <= q.indata;
    end
  fifo_n_ptr #(.depth(depth), .pw(PW)) u_wr (.clk(clk), .reset(reset), .inc(push_ok), .ptr(wr));
  fifo_n_ptr #(.depth(depth), .pw(PW)) u_rd (.clk(clk), .reset(reset), .inc(pop_ok), .ptr(rd));
endmodule

// File: doc/fifo_n.md
# fifo_n

Parametrised synchronous FIFO that generalises the zero-depth pass-through queue to `depth` entries of `width` bits. It keeps the same `addq`/`shiftq`/`full`/`empty` queue handshake, so generated datapaths can swap a zero-depth queue for a buffered one. It adds occupancy reporting, an almost-full threshold and sticky error flags. It sits between a producer and a consumer macrocell in the same clock domain.

## Interface
- `width`, 8: data bits per entry.
- `depth`, 4: number of entries; legal range 2..1024; need not be a power of two.
- `afull_thresh`, depth-1: `almost_full` asserts when count >= this value; legal range 1..depth.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addq`  in  1  push request; `indata` is captured when the push is accepted.
- `shiftq`  in  1  pop request; removes the head entry when the pop is accepted.
- `indata`  in  width  write data.
- `full`  out  1  count == depth.
- `empty`  out  1  no head data available (see Configuration).
- `almost_full`  out  1  count >= afull_thresh.
- `count`  out  CW = clog2(depth+1)  current occupancy.
- `outdata`  out  width  head entry; valid while `empty` is low.
- `overflow`  out  1  sticky flag: a push was dropped.
- `underflow`  out  1  sticky flag: a pop was ignored.

## Operation
- Storage: `depth` × `width` register array, with write pointer `wr` and read pointer `rd`. Each pointer wraps from depth-1 to 0. Non-power-of-two depths use explicit compare-and-clear, not truncation.
- Pop accepted (pop_ok) = `shiftq` && count != 0.
- Push accepted (push_ok) = `addq` && (count != depth || pop_ok). A push onto a full FIFO succeeds when a pop is accepted in the same cycle.
- Next count = count + push_ok − pop_ok.
- On push_ok: write mem[wr] and advance `wr`. On pop_ok: advance `rd`.
- `outdata` = mem[rd] combinationally. When count == 0 it holds whatever mem[rd] contains; consumers must not rely on it.
- `overflow` is set by `addq` && !push_ok.
- `underflow` is set by `shiftq` && count == 0 and no bypass occurs. Both error flags are cleared only by `reset`.
- When pop and push are both accepted on a full FIFO, count stays at depth, the dropped head is replaced by the tail, and no flag is set.

## Timing
- Reset values: count=0, wr=rd=0, full=0, empty=1, almost_full=0, overflow=0, underflow=0, outdata=0. The array is cleared to 0.
- `reset` asserted mid-operation discards all contents asynchronously. The first push is accepted on the first rising edge after deassertion.
- `full`, `almost_full`, `count` and the non-bypass `empty` are decoded from registered count only, so there is no input-to-flag combinational path.
- Write-to-read latency is 1 cycle: data pushed at edge N appears on `outdata`, and `empty` falls, after edge N.
- Pop-to-next-head latency: the new head appears on `outdata` after the popping edge.
- The `addq`-to-accept path is combinational through `shiftq`. Producers must sample `full` only, never the accept term.

## Configuration
- `FIFO_N_BYPASS_EN` defined:
  - When count == 0, `empty` = !`addq` and `outdata` = `indata` combinationally.
  - `addq` && `shiftq` on an empty FIFO passes the data straight through: count stays 0, no write, no underflow.
  - A zero-occupancy FIFO therefore behaves exactly like the pass-through queue.
- Not defined:
  - `empty` = (count == 0), purely registered.
  - Simultaneous `addq`/`shiftq` on an empty FIFO stores the word and sets `underflow`.

## Structure
- Package `fifo_pkg`: clog2 constant function; CW/PW width constants; legal-range limits for `depth`; the `FIFO_N_BYPASS_EN` default commentary.
- One sub-module, `fifo_n_ptr`: a modulo-`depth` pointer with an increment enable and asynchronous reset. It is instantiated twice, for `wr` and `rd`.

## Test plan
- Reset, then 4 pushes of 0x11..0x44 (depth=4): `full`=1 and `count`=4 after the 4th edge. A 5th push sets `overflow`=1 and `outdata` stays 0x11.
- Full FIFO, `addq`=`shiftq`=1 with 0x55: `count` stays 4, no flags set, and the pop sequence yields 0x22, 0x33, 0x44, 0x55.
- Empty FIFO, `shiftq`=1 alone: `underflow`=1, `count`=0, pointers unchanged.
- Empty FIFO, `addq`=`shiftq`=1 with 0xA5:
  - With `FIFO_N_BYPASS_EN`: `outdata`=0xA5 in the same cycle, `count`=0, no flags.
  - Without it: `count`=1, `underflow`=1, then 0xA5 on `outdata`.
- depth=3, afull_thresh=2: 10 push/pop cycles cross the wrap-around boundary. Data order is preserved, and `almost_full` toggles exactly when `count` goes 1→2 and 2→1.
- Assert `reset` asynchronously mid-cycle with `count`=3: all outputs return to reset values before the next edge, and a subsequent push/pop returns the newly pushed word.
